// File: rtl/radio_spi_pkg.sv
// Shared definitions for the radio-board SPI link: field widths,
// FSM state codes and named transceiver register addresses.
package radio_spi_pkg;

  localparam int DEF_DATA_BITS   = 14;
  localparam int DEF_ADDR_BITS   = 4;
  localparam int DEF_WORD_BITS   = DEF_DATA_BITS + DEF_ADDR_BITS;
  localparam int DEF_SYNC_STAGES = 2;

  // Responder FSM state codes
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Transceiver register map, shared with the controller-side master
  localparam logic [DEF_ADDR_BITS-1:0] REG_CFG0    = 4'h0;
  localparam logic [DEF_ADDR_BITS-1:0] REG_CFG1    = 4'h1;
  localparam logic [DEF_ADDR_BITS-1:0] REG_PLL_LO  = 4'h2;
  localparam logic [DEF_ADDR_BITS-1:0] REG_PLL_HI  = 4'h3;
  localparam logic [DEF_ADDR_BITS-1:0] REG_TX_GAIN = 4'h4;
  localparam logic [DEF_ADDR_BITS-1:0] REG_RX_GAIN = 4'h5;
  localparam logic [DEF_ADDR_BITS-1:0] REG_FILTER  = 4'h6;
  localparam logic [DEF_ADDR_BITS-1:0] REG_STATUS  = 4'hF;

endpackage

// File: rtl/radio_spi_sync.sv
// N-stage synchronizer with a configurable reset level.
// Ports: clk, reset (async, high), d (async in), q (synchronized out).
module radio_spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {STAGES{RST_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/radio_spi_responder.sv
// Radio-side SPI responder: turns spi_clk/spi_data/spi_cs frames into
// register writes and keeps a shadow copy of every transceiver register.
// Ports: clk, reset (async, high); spi_clk/spi_data/spi_cs (async SPI in);
//   wr_valid/wr_addr/wr_data (commit strobe + fields), frame_err (bad
//   length strobe), busy (frame in progress); rd_addr -> rd_data (comb read).
module radio_spi_responder #(
  parameter int DATA_BITS   = radio_spi_pkg::DEF_DATA_BITS,
  parameter int ADDR_BITS   = radio_spi_pkg::DEF_ADDR_BITS,
  parameter int WORD_BITS   = radio_spi_pkg::DEF_WORD_BITS,
  parameter int SYNC_STAGES = radio_spi_pkg::DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spi_clk,
  input  logic                 spi_data,
  input  logic                 spi_cs,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 busy,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  import radio_spi_pkg::*;

  localparam int DEPTH    = 2 ** ADDR_BITS;
  localparam int CNT_W    = $clog2(WORD_BITS + 2);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);

  logic clk_s, data_s, cs_s;

  radio_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .reset(reset), .d(spi_clk), .q(clk_s)
  );
  radio_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .reset(reset), .d(spi_data), .q(data_s)
  );
  radio_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(spi_cs), .q(cs_s)
  );

  logic                 clk_d_q, clk_d_d;
  logic                 cs_d_q, cs_d_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 armed_q, armed_d;
  logic [1:0]           state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];

  logic clk_rise, cs_fall, cs_rise, start;

  assign clk_rise = clk_s & ~clk_d_q;
  assign cs_fall  = ~cs_s & cs_d_q;
  assign cs_rise  = cs_s & ~cs_d_q;
  // The cs synchronizer resets high, so a cs held low through reset would
  // look like a fresh falling edge. Frames are only accepted once cs has
  // been seen genuinely high after the synchronizer has filled.
  assign start    = cs_fall & armed_q;

  always_comb begin
    clk_d_d  = clk_s;
    cs_d_d   = cs_s;
    settle_d = (settle_q == SETTLE_DONE) ? settle_q
                                         : settle_q + SETTLE_W'(1);
    armed_d  = armed_q | ((settle_q == SETTLE_DONE) & cs_s);
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_d       = mem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d = ST_COMMIT;
        end else if (clk_rise) begin
          shift_d = {shift_q[WORD_BITS-2:0], data_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        if (cnt_q == CNT_FULL) begin
          wr_valid_d       = 1'b1;
          wr_data_d        = shift_q[WORD_BITS-1:ADDR_BITS];
          wr_addr_d        = shift_q[ADDR_BITS-1:0];
          mem_d[wr_addr_d] = wr_data_d;
        end else begin
          frame_err_d = 1'b1;
        end
        if (start) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_d_q     <= 1'b0;
      cs_d_q      <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mem_q       <= '{default: '0};
    end else begin
      clk_d_q     <= clk_d_d;
      cs_d_q      <= cs_d_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      mem_q       <= mem_d;
    end
  end

  assign wr_valid  = wr_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = mem_q[rd_addr];

endmodule

// File: tb/tb_radio_spi_responder.sv
// Randomized bench for radio_spi_responder against a frame-level model:
// a legal frame is exactly 18 bits, data first, and updates a shadow array.
module tb_radio_spi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_data, spi_cs;
  logic        wr_valid, frame_err, busy;
  logic [3:0]  wr_addr, rd_addr;
  logic [13:0] wr_data, rd_data;

  int checks = 0;
  int errors = 0;

  logic [13:0] model_mem [16];
  logic [3:0]  last_addr;
  logic [13:0] last_data;

  radio_spi_responder dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_data(spi_data), .spi_cs(spi_cs),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err), .busy(busy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low(input int half);
    @(negedge clk);
    spi_cs = 1'b0;
    wait_clk(half);
  endtask

  // Sends v[n-1:0], MSB first, one bit per SPI clock period
  task automatic send_bits(input int n, input logic [31:0] v,
                           input int half);
    for (int i = n - 1; i >= 0; i--) begin
      spi_data = v[i];
      wait_clk(half);
      spi_clk = 1'b1;
      wait_clk(half);
      spi_clk = 1'b0;
    end
  endtask

  task automatic observe(input int cycles, output int nv, output int ne,
                         output int fv, output int fe);
    nv = 0; ne = 0; fv = -1; fe = -1;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk);
      #1;
      if (wr_valid) begin nv++; if (fv < 0) fv = c; end
      if (frame_err) begin ne++; if (fe < 0) fe = c; end
    end
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s shadow[%0d]", tag, a), 32'(rd_data),
          32'(model_mem[a]));
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 16; a++) model_mem[a] = '0;
    last_addr = '0;
    last_data = '0;
  endtask

  task automatic run_frame(input string tag, input int n,
                           input logic [31:0] v, input int half);
    int nv, ne, fv, fe;
    logic legal;
    logic [3:0] ra;
    cs_low(half);
    send_bits(n, v, half);
    if (n > 0) chk({tag, " busy_mid"}, 32'(busy), 32'd1);
    wait_clk(half);
    spi_cs   = 1'b1;
    spi_data = 1'b0;
    observe(8, nv, ne, fv, fe);
    legal = (n == 18);
    if (legal) begin
      last_addr = v[3:0];
      last_data = v[17:4];
      model_mem[last_addr] = last_data;
    end
    chk({tag, " wr_valid_cnt"}, 32'(nv), legal ? 32'd1 : 32'd0);
    chk({tag, " frame_err_cnt"}, 32'(ne), legal ? 32'd0 : 32'd1);
    chk({tag, " latency"}, legal ? 32'(fv) : 32'(fe), 32'd4);
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'(last_addr));
    chk({tag, " wr_data"}, 32'(wr_data), 32'(last_data));
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    rd_addr = v[3:0];
    #1;
    chk({tag, " rd_frame_addr"}, 32'(rd_data), 32'(model_mem[v[3:0]]));
    ra = 4'($urandom);
    rd_addr = ra;
    #1;
    chk({tag, " rd_rand"}, 32'(rd_data), 32'(model_mem[ra]));
  endtask

  initial begin
    int bad;
    int nv, ne, fv, fe;
    int lens [11];
    logic [31:0] v;
    lens = '{0, 1, 16, 17, 18, 18, 18, 18, 19, 20, 25};

    spi_clk  = 1'b0;
    spi_data = 1'b0;
    spi_cs   = 1'b1;
    rd_addr  = '0;
    reset    = 1'b1;
    model_reset();

    wait_clk(3);
    chk("rst wr_valid", 32'(wr_valid), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    reset = 1'b0;
    wait_clk(4);
    check_all("rst");

    run_frame("legal", 18, {14'h2A5C, 4'h5}, 4);
    check_all("legal");

    run_frame("short17", 17, $urandom, 4);
    run_frame("long19", 19, $urandom, 4);
    check_all("short_long");

    run_frame("b2b_a", 18, {14'h3FFF, 4'h3}, 4);
    run_frame("b2b_b", 18, {14'h0001, 4'h3}, 4);
    check_all("b2b");

    bad = 0;
    for (int i = 0; i < 20; i++) begin
      spi_clk  = ~spi_clk;
      spi_data = 1'($urandom);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        if (busy || wr_valid || frame_err) bad++;
      end
    end
    spi_clk = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy || wr_valid || frame_err) bad++;
    end
    chk("stray activity", 32'(bad), 32'd0);
    run_frame("after_stray", 18, $urandom, 4);

    v = $urandom;
    cs_low(4);
    send_bits(9, v >> 9, 4);
    reset = 1'b1;
    wait_clk(2);
    model_reset();
    chk("midrst wr_valid", 32'(wr_valid), 32'd0);
    chk("midrst frame_err", 32'(frame_err), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst wr_data", 32'(wr_data), 32'd0);
    check_all("midrst");
    @(negedge clk);
    reset = 1'b0;
    send_bits(9, v & 32'h1FF, 4);
    wait_clk(4);
    spi_cs   = 1'b1;
    spi_data = 1'b0;
    observe(10, nv, ne, fv, fe);
    chk("midrst tail wr_valid", 32'(nv), 32'd0);
    chk("midrst tail frame_err", 32'(ne), 32'd0);
    run_frame("after_rst", 18, $urandom, 4);
    check_all("after_rst");

    run_frame("zero_len", 0, 32'd0, 2);
    run_frame("min_ratio", 18, $urandom, 2);

    for (int i = 0; i < 30; i++) begin
      run_frame($sformatf("rnd%0d", i),
                lens[$urandom_range(0, 10)], $urandom,
                int'($urandom_range(2, 5)));
    end
    check_all("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
